// File: rtl/wa_port_arbiter_pkg.sv
// Shared definitions for the register-file write-address port arbiter.
// Exports the FSM state encoding and the requester count.
package wa_port_arbiter_pkg;

   localparam int NREQ = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/wa_port_arbiter_rr_pick4.sv
// Combinational round-robin picker over 4 requesters.
// Ports: req[3:0], ptr[1:0] (highest-priority index) -> any, idx[1:0].
import wa_port_arbiter_pkg::*;

module rr_pick4 (
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   output logic            any,
   output logic [1:0]      idx
);

   logic [1:0] k;

   // Walk the offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      any = |req;
      idx = ptr;
      k   = ptr;
      for (int i = NREQ - 1; i >= 0; i--) begin
         k = ptr + 2'(i);
         if (req[k]) idx = k;
      end
   end

endmodule

// File: rtl/wa_port_arbiter.sv
// Round-robin owner arbiter for the shared 4:1 write-address mux.
// Ports: clk, rst, req[3:0], rel -> gnt[3:0], sel[1:0], busy, timeout.
import wa_port_arbiter_pkg::*;

module wa_port_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            rel,
   output logic [NREQ-1:0] gnt,
   output logic [1:0]      sel,
   output logic            busy,
   output logic            timeout
);

   localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

   state_t        state;
   logic [1:0]    ptr;
   logic [CW-1:0] hold_cnt;
   logic          any;
   logic [1:0]    idx;
   logic          own_req;
   logic          tmo_hit;
   logic          rc;

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr),
      .any (any),
      .idx (idx)
   );

   always_comb begin
      own_req = req[sel];
      tmo_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
      rc      = rel | ~own_req | tmo_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         sel      <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (any) begin
                  gnt      <= 4'b0001 << idx;
                  sel      <= idx;
                  busy     <= 1'b1;
                  hold_cnt <= CW'(1);
                  state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (rc) begin
                  gnt   <= '0;
                  busy  <= 1'b0;
                  ptr   <= sel + 2'd1;
                  state <= ST_IDLE;
                  // Flag only releases forced purely by the hold limit.
                  timeout <= tmo_hit & ~rel & own_req;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wa_port_arbiter.sv
// Scoreboard bench for wa_port_arbiter.
// Expected outputs queued per driven cycle; directed checks inline.
module tb_wa_port_arbiter;

   localparam int MH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic       rel = 1'b0;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       timeout;

   int nvec = 0;
   int nbad = 0;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       timeout;
   } exp_t;

   exp_t q[$];

   // reference state
   logic       m_grant = 1'b0;
   int         m_ptr = 0;
   int         m_cnt = 0;
   exp_t       m_out = '0;

   wa_port_arbiter #(.MAX_HOLD(MH)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .rel     (rel),
      .gnt     (gnt),
      .sel     (sel),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_step(input logic rs, input logic [3:0] rq,
                             input logic rl);
      int  w;
      logic tmo;
      logic own;
      if (rs) begin
         m_grant = 1'b0;
         m_ptr   = 0;
         m_cnt   = 0;
         m_out   = '0;
      end else if (!m_grant) begin
         m_out.timeout = 1'b0;
         w = -1;
         for (int k = 3; k >= 0; k--)
            if (rq[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
         if (w >= 0) begin
            m_out.gnt  = 4'(1 << w);
            m_out.sel  = 2'(w);
            m_out.busy = 1'b1;
            m_cnt      = 1;
            m_grant    = 1'b1;
         end
      end else begin
         own = rq[m_out.sel];
         tmo = (m_cnt == MH);
         if (rl || !own || tmo) begin
            m_out.gnt     = '0;
            m_out.busy    = 1'b0;
            m_out.timeout = tmo && !rl && own;
            m_ptr         = (int'(m_out.sel) + 1) % 4;
            m_grant       = 1'b0;
         end else begin
            m_out.timeout = 1'b0;
            m_cnt++;
         end
      end
   endtask

   task automatic apply(input logic rs, input logic [3:0] rq,
                        input logic rl);
      @(negedge clk);
      rst = rs;
      req = rq;
      rel = rl;
      model_step(rs, rq, rl);
      q.push_back(m_out);
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         nvec++;
         if ({gnt, sel, busy, timeout} !== e) begin
            nbad++;
            $display("FAIL sb t=%0t gnt/sel/busy/to got %b/%0d/%b/%b exp %b/%0d/%b/%b",
                     $time, gnt, sel, busy, timeout,
                     e.gnt, e.sel, e.busy, e.timeout);
         end
      end
   end

   task automatic test_reset();
      apply(1'b1, 4'b0000, 1'b0);
      apply(1'b1, 4'b1111, 1'b1);
      nvec++;
      if ({gnt, sel, busy, timeout} !== 8'b0) begin
         nbad++;
         $display("FAIL reset got %b/%0d/%b/%b exp 0000/0/0/0",
                  gnt, sel, busy, timeout);
      end
   endtask

   task automatic test_first_grant();
      apply(1'b0, 4'b1010, 1'b0);
      nvec++;
      if (gnt !== 4'b0010 || sel !== 2'd1 || busy !== 1'b1 ||
          timeout !== 1'b0) begin
         nbad++;
         $display("FAIL first_grant got %b/%0d/%b/%b exp 0010/1/1/0",
                  gnt, sel, busy, timeout);
      end
   endtask

   task automatic test_release();
      apply(1'b0, 4'b1010, 1'b1);
      nvec++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
         nbad++;
         $display("FAIL release_gap got gnt=%b busy=%b exp 0000/0", gnt, busy);
      end
      apply(1'b0, 4'b1010, 1'b0);
      nvec++;
      if (gnt !== 4'b1000 || sel !== 2'd3) begin
         nbad++;
         $display("FAIL release_next got gnt=%b sel=%0d exp 1000/3", gnt, sel);
      end
      apply(1'b0, 4'b1010, 1'b1);
   endtask

   task automatic test_round_robin();
      apply(1'b1, 4'b0000, 1'b0);
      for (int n = 0; n < 5; n++) begin
         apply(1'b0, 4'b1111, 1'b0);
         nvec++;
         if (gnt !== 4'(1 << (n % 4))) begin
            nbad++;
            $display("FAIL rr_owner n=%0d got %b exp %b",
                     n, gnt, 4'(1 << (n % 4)));
         end
         apply(1'b0, 4'b1111, 1'b0);
         apply(1'b0, 4'b1111, 1'b1);
         nvec++;
         if (gnt !== 4'b0000) begin
            nbad++;
            $display("FAIL rr_gap n=%0d got %b exp 0000", n, gnt);
         end
      end
   endtask

   task automatic test_timeout();
      int held;
      apply(1'b1, 4'b0000, 1'b0);
      held = 0;
      for (int c = 0; c < MH + 4 && (c == 0 || gnt == 4'b0001); c++) begin
         apply(1'b0, 4'b0001, 1'b0);
         if (gnt == 4'b0001) held++;
      end
      nvec++;
      if (held !== MH || gnt !== 4'b0000 || timeout !== 1'b1) begin
         nbad++;
         $display("FAIL timeout held=%0d exp %0d gnt=%b to=%b exp 0000/1",
                  held, MH, gnt, timeout);
      end
      apply(1'b0, 4'b0001, 1'b0);
      nvec++;
      if (gnt !== 4'b0001 || timeout !== 1'b0) begin
         nbad++;
         $display("FAIL timeout_regrant got %b to=%b exp 0001/0", gnt, timeout);
      end
      for (int c = 1; c < MH; c++) apply(1'b0, 4'b0001, 1'b0);
      apply(1'b0, 4'b0001, 1'b1);
      nvec++;
      if (gnt !== 4'b0000 || timeout !== 1'b0) begin
         nbad++;
         $display("FAIL rel_and_tmo got %b to=%b exp 0000/0", gnt, timeout);
      end
   endtask

   task automatic test_drop();
      apply(1'b1, 4'b0000, 1'b0);
      apply(1'b0, 4'b0100, 1'b0);
      apply(1'b0, 4'b0100, 1'b0);
      apply(1'b0, 4'b0000, 1'b0);
      nvec++;
      if (gnt !== 4'b0000 || timeout !== 1'b0) begin
         nbad++;
         $display("FAIL drop got %b to=%b exp 0000/0", gnt, timeout);
      end
      apply(1'b0, 4'b1111, 1'b0);
      nvec++;
      if (gnt !== 4'b1000) begin
         nbad++;
         $display("FAIL drop_ptr got %b exp 1000", gnt);
      end
      apply(1'b0, 4'b1111, 1'b1);
   endtask

   task automatic test_reset_mid();
      apply(1'b1, 4'b0000, 1'b0);
      apply(1'b0, 4'b0100, 1'b0);
      apply(1'b1, 4'b0100, 1'b0);
      nvec++;
      if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0) begin
         nbad++;
         $display("FAIL reset_mid got %b/%0d/%b exp 0000/0/0", gnt, sel, busy);
      end
      apply(1'b0, 4'b1111, 1'b0);
      nvec++;
      if (gnt !== 4'b0001) begin
         nbad++;
         $display("FAIL reset_mid_grant got %b exp 0001", gnt);
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      for (int i = 0; i < 300; i++) begin
         r = 4'($urandom_range(0, 15));
         apply(($urandom_range(0, 63) == 0), r,
               ($urandom_range(0, 5) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_release();
      test_round_robin();
      test_timeout();
      test_drop();
      test_reset_mid();
      test_random();
      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
